// File: rtl/inst_loader.sv
// rtl/inst_loader.sv - byte-stream program loader for the instruction memory LOAD port
//
// Packs INST_WIDTH/8 host bytes MSB-first into one instruction word, writes it
// at the memory's current pc, and paces the auto-incrementing pc with stall.
// An END_MARKER word (never written) or a full memory ends the load, rewinds
// pc and switches the core to EXEC. A reload pulse in EXEC starts a new load.
//
// Ports:
//   clk, rstn               clock, asynchronous active-low reset
//   byte_in/byte_valid      host byte stream
//   byte_ready              byte accepted when byte_valid && byte_ready
//   inst_out                assembled word, to memory inst_in
//   we                      memory write enable (WRITE state only)
//   stall                   holds memory pc (low only in WRITE and EXEC)
//   reset_pc                forces memory pc to 0 (INIT, FINISH)
//   mode                    0 = LOAD, 1 = EXEC
//   reload                  one-cycle request to re-enter LOAD, honoured in EXEC
//   word_count              words written since the last INIT
//   overflow                sticky: memory filled before the marker arrived

module inst_loader #(
    parameter int                    INST_WIDTH     = 32,
    parameter int                    INST_MEM_WIDTH = 12,
    parameter logic [INST_WIDTH-1:0] END_MARKER     = 32'hFFFF_FFFF
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [7:0]                byte_in,
    input  logic                      byte_valid,
    output logic                      byte_ready,
    output logic [INST_WIDTH-1:0]     inst_out,
    output logic                      we,
    output logic                      stall,
    output logic                      reset_pc,
    output logic                      mode,
    input  logic                      reload,
    output logic [INST_MEM_WIDTH:0]   word_count,
    output logic                      overflow
);

    localparam int BYTES = INST_WIDTH / 8;
    localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;

    localparam logic [BCW-1:0]          LAST_BYTE = BCW'(BYTES - 1);
    localparam logic [INST_MEM_WIDTH:0] LAST_ADDR = {1'b0, {INST_MEM_WIDTH{1'b1}}};

    typedef enum logic [2:0] {
        S_INIT,
        S_RECV,
        S_WRITE,
        S_FINISH,
        S_EXEC
    } state_t;

    state_t                   state;
    logic [BCW-1:0]           byte_cnt;
    logic [INST_WIDTH+7:0]    shifted;
    logic [INST_WIDTH-1:0]    inst_next;
    logic                     accept;
    logic                     last_byte;

    // Shift through a wider vector so the slice stays legal even for 8-bit words.
    assign shifted   = {inst_out, byte_in};
    assign inst_next = shifted[INST_WIDTH-1:0];
    assign accept    = byte_valid && byte_ready;
    assign last_byte = (byte_cnt == LAST_BYTE);

    // Moore decode: every control output is a pure function of the state register,
    // so an asynchronous reset moves them immediately.
    assign byte_ready = (state == S_RECV);
    assign we         = (state == S_WRITE);
    assign reset_pc   = (state == S_INIT) || (state == S_FINISH);
    assign stall      = (state == S_INIT) || (state == S_RECV) || (state == S_FINISH);
    assign mode       = (state == S_EXEC);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= S_INIT;
            inst_out   <= '0;
            word_count <= '0;
            overflow   <= 1'b0;
            byte_cnt   <= '0;
        end else begin
            case (state)
                S_INIT: begin
                    word_count <= '0;
                    overflow   <= 1'b0;
                    byte_cnt   <= '0;
                    state      <= S_RECV;
                end
                S_RECV: begin
                    if (accept) begin
                        inst_out <= inst_next;
                        byte_cnt <= last_byte ? '0 : byte_cnt + BCW'(1);
                        if (last_byte) begin
                            // The marker is judged on the word as it will be after
                            // this byte lands, and is never written to memory.
                            state <= (inst_next == END_MARKER) ? S_FINISH : S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    word_count <= word_count + (INST_MEM_WIDTH+1)'(1);
                    if (word_count == LAST_ADDR) begin
                        overflow <= 1'b1;
                        state    <= S_FINISH;
                    end else begin
                        state <= S_RECV;
                    end
                end
                S_FINISH: begin
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    if (reload) begin
                        state <= S_INIT;
                    end
                end
                default: begin
                    state <= S_INIT;
                end
            endcase
        end
    end

endmodule

// File: doc/inst_loader.md
# inst_loader

Program loader at the write end of the instruction memory's LOAD-mode port. It accepts a byte stream from the host link (UART receiver), packs each group of four bytes MSB-first into one instruction word, and writes it at the instruction memory's current pc. It paces the memory's auto-incrementing pc using `stall`, and detects the end-of-program marker. It then rewinds pc and hands the core over to EXEC mode.

## Interface
Parameters:
- `INST_WIDTH`, 32: instruction word width. It must be a multiple of 8.
- `INST_MEM_WIDTH`, 12: instruction memory address width. Capacity is 2**INST_MEM_WIDTH words.
- `END_MARKER`, 32'hFFFF_FFFF: terminating word. It is never written to memory.

Ports:
- `clk`  in  1  the single clock. All logic is on the rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `byte_in`  in  8  byte from the host link.
- `byte_valid`  in  1  `byte_in` holds a valid byte.
- `byte_ready`  out  1  loader accepts a byte this cycle. A transfer happens when `byte_valid && byte_ready`.
- `inst_out`  out  INST_WIDTH  assembled word. It connects to the memory's `inst_in`.
- `we`  out  1  instruction memory write enable.
- `stall`  out  1  holds the memory pc. It is ORed externally with the pipeline stall sources.
- `reset_pc`  out  1  forces the memory pc to 0.
- `mode`  out  mode_t  LOAD or EXEC. This is the global mode.
- `reload`  in  1  single-cycle request to re-enter LOAD. It is honoured only in EXEC.
- `word_count`  out  INST_MEM_WIDTH+1  number of words written since the last INIT.
- `overflow`  out  1  memory filled before the marker arrived. The flag is sticky until the next INIT.

## Operation
- States are INIT, RECV, WRITE, FINISH and EXEC. The outputs are Moore-decoded from the state register. `inst_out`, `word_count` and `overflow` are registered.
- While `rstn` is low, the state is INIT, `inst_out`=0, `word_count`=0, `overflow`=0 and `byte_cnt`=0. The decoded outputs are therefore `reset_pc`=1, `stall`=1, `mode`=LOAD, `we`=0 and `byte_ready`=0.
- INIT: `reset_pc`=1, `stall`=1. It clears `word_count`, `overflow` and `byte_cnt`, then goes to RECV.
- RECV: `byte_ready`=1, `stall`=1.
  - Each accepted byte shifts into `inst_out`: `inst_out <= {inst_out[INST_WIDTH-9:0], byte_in}`. `byte_cnt` then increments, wrapping at INST_WIDTH/8.
  - On the last byte of a word, the next-cycle value of `inst_out` is compared with END_MARKER. A match goes to FINISH. Otherwise the state goes to WRITE.
- WRITE: `we`=1, `stall`=0, `byte_ready`=0. The memory writes `inst_out` at its pc and increments its pc in this same cycle.
  - `word_count` increments.
  - If `word_count` was 2**INST_MEM_WIDTH-1 (the last address is being written), `overflow` is set and the next state is FINISH.
  - Otherwise the next state is RECV.
- FINISH: `reset_pc`=1, `stall`=1, `mode`=LOAD, `byte_ready`=0. The next state is EXEC.
- EXEC: `mode`=EXEC, `stall`=0, `we`=0, `byte_ready`=0. Bytes arriving in this state are not accepted and are left to the link's own buffering. A `reload` pulse goes to INIT.
- `reload` has no effect outside EXEC.
- `we` is asserted only in WRITE. `stall` is deasserted in LOAD mode only in WRITE, so the memory pc advances exactly once per written word.
- `word_count` and `overflow` hold their values through EXEC until the next INIT.

## Timing
- Reset release: first edge with `rstn` high goes INIT→RECV. `byte_ready` is 1 in the cycle after release.
- Final byte of a word accepted at edge N: WRITE is active in cycle N→N+1, and `we` is sampled at edge N+1. RECV resumes after edge N+1.
- Maximum rate is one word per (INST_WIDTH/8)+1 cycles. `byte_ready`=0 during WRITE.
- Marker word: final byte at edge N, FINISH in cycle N→N+1 with `reset_pc` sampled at edge N+1, EXEC from edge N+1. The first fetch happens from address 0.
- Overflow: the write of the last address at edge N is followed by FINISH and then EXEC. No further bytes are accepted.
- A `reload` sampled at edge N in EXEC puts INIT in the following cycle and `mode`=LOAD in the same cycle.
- An asynchronous `rstn` assertion mid-word discards the partial word and the count, with the outputs changing immediately.
- `byte_valid` may stay high through WRITE. That byte is transferred in the next RECV cycle, with no loss or duplication.

## Test plan
- Reset then stream 00 11 22 33, AA BB CC DD, FF FF FF FF, with `byte_valid` continuously high:
  - `we` pulses twice, with `inst_out`=32'h00112233 and then 32'hAABBCCDD.
  - `reset_pc` pulses at the INIT and FINISH steps.
  - End state: `mode`=EXEC, `word_count`=2.
- Random gaps in `byte_valid`, including `byte_valid` low during WRITE: identical words and count. Each byte is accepted exactly once.
- INST_MEM_WIDTH=2, 5 non-marker words: 4 `we` pulses, then `overflow`=1 and `mode`=EXEC with `word_count`=4. The 5th word's bytes are not accepted.
- Marker as the first word: no `we` pulse, `word_count`=0, `mode`=EXEC after INIT→RECV(4 bytes)→FINISH.
- In EXEC, pulse `reload`, then load 1 word plus the marker:
  - `mode` goes to LOAD, then `reset_pc`=1 with counters cleared.
  - Final `word_count`=1.
- `rstn` low after 2 bytes of a word, then release and send 4 fresh bytes 12 34 56 78: the first `we` carries 32'h12345678.
